// File: rtl/rnd_seq_checker_pkg.sv
// Shared definitions for the LFSR sequence checker: FSM states, tap
// positions and the 8-bit LFSR step function. The step function is meant
// to be reused by any generator variant, so the checker and the source
// always agree on the sequence.
package rnd_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Feedback taps of the 8-bit generator.
    localparam int TAP_A = 7;
    localparam int TAP_B = 5;
    localparam int TAP_C = 3;
    localparam int TAP_D = 0;

    // One shift of the generator: shift left, feed the tap XOR into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
    endfunction

endpackage

// File: rtl/rnd_seq_checker_if.sv
// Sample stream and status bundle between the random source side and the
// sequence checker. When RND_SEQ_CHECKER_CLR_EN is defined an extra err_clr
// request is carried from the master to the checker.
interface rnd_seq_checker_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int CNT_W         = 16
);
    logic [DATAWIDTH_BUS-1:0] rnd_in;
    logic                     rnd_valid;
    logic                     locked;
    logic                     err_pulse;
    logic [CNT_W-1:0]         err_count;
    logic [DATAWIDTH_BUS-1:0] expected;
`ifdef RND_SEQ_CHECKER_CLR_EN
    logic                     err_clr;

    modport master (
        output rnd_in, rnd_valid, err_clr,
        input  locked, err_pulse, err_count, expected
    );
    modport slave (
        input  rnd_in, rnd_valid, err_clr,
        output locked, err_pulse, err_count, expected
    );
`else
    modport master (
        output rnd_in, rnd_valid,
        input  locked, err_pulse, err_count, expected
    );
    modport slave (
        input  rnd_in, rnd_valid,
        output locked, err_pulse, err_count, expected
    );
`endif
endinterface

// File: rtl/rnd_seq_checker.sv
// Receive-side checker for the 8-bit LFSR random source. Locks onto the
// incoming byte stream, predicts the next sample, counts mispredictions
// while locked and reports lock status. All outputs are registered.
// Optional feature macro: RND_SEQ_CHECKER_CLR_EN (adds err_clr to the bus).
module rnd_seq_checker
    import rnd_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,   // only 8 is meaningful with fixed taps
    parameter int LOCK_COUNT    = 4,   // 1..15
    parameter int UNLOCK_COUNT  = 3,   // 1..15
    parameter int CNT_W         = 16
) (
    input  logic         clock,
    input  logic         reset,
    rnd_seq_checker_if.slave bus
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    state_t                   state_reg, state_next;
    logic [DATAWIDTH_BUS-1:0] exp_reg, exp_next;
    logic [3:0]               match_cnt_reg, match_cnt_next;
    logic [3:0]               miss_cnt_reg, miss_cnt_next;
    logic                     locked_reg, locked_next;
    logic                     err_pulse_reg, err_pulse_next;
    logic [CNT_W-1:0]         err_count_reg, err_count_next;

    logic [DATAWIDTH_BUS-1:0] step_exp;   // flywheel prediction
    logic [DATAWIDTH_BUS-1:0] seed_exp;   // prediction reseeded from the sample
    logic                     hit;
    logic [3:0]               match_inc;
    logic [3:0]               miss_inc;

    assign step_exp  = lfsr_next(exp_reg);
    assign seed_exp  = lfsr_next(bus.rnd_in);
    assign hit       = (bus.rnd_in == exp_reg);
    assign match_inc = match_cnt_reg + 4'd1;
    assign miss_inc  = miss_cnt_reg + 4'd1;

    // Next-state, prediction and error counter logic; holds everything when no sample is valid.
    always_comb begin
        state_next     = state_reg;
        exp_next       = exp_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        locked_next    = locked_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;

        if (bus.rnd_valid) begin
            case (state_reg)
                HUNT: begin
                    // 0x00 is the dead state of the LFSR and can never seed it.
                    if (bus.rnd_in != '0) begin
                        exp_next       = seed_exp;
                        match_cnt_next = 4'd0;
                        state_next     = SYNC;
                    end
                end
                SYNC: begin
                    if (hit) begin
                        exp_next       = step_exp;
                        match_cnt_next = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_next    = LOCKED;
                            locked_next   = 1'b1;
                            miss_cnt_next = 4'd0;
                        end
                    end else if (bus.rnd_in == '0) begin
                        state_next     = HUNT;
                        match_cnt_next = 4'd0;
                    end else begin
                        exp_next       = seed_exp;
                        match_cnt_next = 4'd0;
                    end
                end
                LOCKED: begin
                    // Once locked, keep flywheeling so isolated bit errors do not lose sync.
                    exp_next = step_exp;
                    if (hit) begin
                        miss_cnt_next = 4'd0;
                    end else begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != {CNT_W{1'b1}}) begin
                            err_count_next = err_count_reg + 1'b1;
                        end
                        miss_cnt_next = miss_inc;
                        if (miss_inc == UNLOCK_N) begin
                            state_next  = HUNT;
                            locked_next = 1'b0;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end

`ifdef RND_SEQ_CHECKER_CLR_EN
        // A clear request wins over a simultaneous increment; the pulse still fires.
        if (bus.err_clr) begin
            err_count_next = '0;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= HUNT;
            exp_reg       <= '0;
            match_cnt_reg <= 4'd0;
            miss_cnt_reg  <= 4'd0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            exp_reg       <= exp_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
        end
    end

    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.err_count = err_count_reg;
    assign bus.expected  = exp_reg;

endmodule

// File: tb/tb_rnd_seq_checker.sv
// Self-checking bench for rnd_seq_checker. Two instances: dut0 with the
// default parameters and dut1 with CNT_W=2 / UNLOCK_COUNT=15 for the
// saturation case. A behavioural model tracks the expected outputs.
module tb_rnd_seq_checker;

    logic clock;
    logic reset;

    rnd_seq_checker_if #(.DATAWIDTH_BUS(8), .CNT_W(16)) bus0 ();
    rnd_seq_checker_if #(.DATAWIDTH_BUS(8), .CNT_W(2))  bus1 ();

    rnd_seq_checker #(
        .DATAWIDTH_BUS(8), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(16)
    ) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );

    rnd_seq_checker #(
        .DATAWIDTH_BUS(8), .LOCK_COUNT(4), .UNLOCK_COUNT(15), .CNT_W(2)
    ) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // mode: 0 = searching, 1 = confirming, 2 = locked
    int         m_mode   [2];
    logic [7:0] m_exp    [2];
    int         m_run    [2];
    int         m_bad    [2];
    bit         m_locked [2];
    bit         m_pulse  [2];
    int         m_errs   [2];
    int         lock_n   [2] = '{4, 4};
    int         unlock_n [2] = '{3, 15};
    int         cmax     [2] = '{65535, 3};

    logic [7:0] lock_seq [5] = '{8'h81, 8'h02, 8'h04, 8'h08, 8'h11};

    // Generator step as arithmetic: double modulo 256, plus parity of taps 7,5,3,0.
    function automatic logic [7:0] nx(input logic [7:0] x);
        int v;
        v = (int'(x) * 2) % 256 + ($countones(x & 8'hA9) % 2);
        return v[7:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_exp[i] = 8'h00; m_run[i] = 0; m_bad[i] = 0;
            m_locked[i] = 1'b0; m_pulse[i] = 1'b0; m_errs[i] = 0;
        end
    endtask

    task automatic model_sample(input int id, input logic [7:0] d);
        if (m_mode[id] == 0) begin
            if (d != 8'h00) begin
                m_exp[id] = nx(d); m_run[id] = 0; m_mode[id] = 1;
            end
        end else if (m_mode[id] == 1) begin
            if (d == m_exp[id]) begin
                m_exp[id] = nx(m_exp[id]);
                m_run[id]++;
                if (m_run[id] == lock_n[id]) begin
                    m_mode[id] = 2; m_locked[id] = 1'b1; m_bad[id] = 0;
                end
            end else if (d == 8'h00) begin
                m_mode[id] = 0; m_run[id] = 0;
            end else begin
                m_exp[id] = nx(d); m_run[id] = 0;
            end
        end else begin
            if (d == m_exp[id]) begin
                m_bad[id] = 0;
            end else begin
                m_pulse[id] = 1'b1;
                if (m_errs[id] < cmax[id]) m_errs[id]++;
                m_bad[id]++;
                if (m_bad[id] == unlock_n[id]) begin
                    m_mode[id] = 0; m_locked[id] = 1'b0;
                end
            end
            m_exp[id] = nx(m_exp[id]);
        end
    endtask

    function automatic logic [25:0] mdl(input int id);
        return {m_locked[id], m_pulse[id], 16'(m_errs[id]), m_exp[id]};
    endfunction

    function logic [25:0] obs(input int id);
        if (id == 0) return {bus0.locked, bus0.err_pulse, bus0.err_count, bus0.expected};
        return {bus1.locked, bus1.err_pulse, 14'd0, bus1.err_count, bus1.expected};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic step(input int id, input bit v, input logic [7:0] d, input bit clr);
        @(negedge clock);
        reset          = 1'b0;
        bus0.rnd_valid = (id == 0) && v;
        bus0.rnd_in    = d;
        bus1.rnd_valid = (id == 1) && v;
        bus1.rnd_in    = d;
`ifdef RND_SEQ_CHECKER_CLR_EN
        bus0.err_clr   = (id == 0) && clr;
        bus1.err_clr   = (id == 1) && clr;
`endif
        m_pulse[0] = 1'b0;
        m_pulse[1] = 1'b0;
        if (v) model_sample(id, d);
`ifdef RND_SEQ_CHECKER_CLR_EN
        if (clr) m_errs[id] = 0;
`endif
        @(posedge clock);
        #1;
        $display("[TB] dut%0d v=%0d d=%02h clr=%0d -> out=%07h model=%07h",
                 id, v, d, clr, obs(id), mdl(id));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset          = 1'b1;
        bus0.rnd_valid = 1'b1;
        bus0.rnd_in    = 8'($urandom);
        bus1.rnd_valid = 1'b1;
        bus1.rnd_in    = 8'($urandom);
        model_clear();
        @(posedge clock);
        #1;
        $display("[TB] reset with valid=1 -> dut0=%07h dut1=%07h", obs(0), obs(1));
    endtask

    task automatic do_lock(input int id);
        for (int i = 0; i < 5; i++) step(id, 1'b1, lock_seq[i], 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (obs(0) !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %07h want 0000000", obs(0));
        end
        n_tests++;
        if (obs(1) !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %07h want 0000000", obs(1));
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b1, lock_seq[i], 1'b0);
            n_tests++;
            if (obs(0) !== mdl(0)) begin
                n_fail++;
                $display("FAIL lock_step%0d: got %07h want %07h", i, obs(0), mdl(0));
            end
        end
        n_tests++;
        if ({bus0.locked, bus0.expected, bus0.err_count} !== {1'b1, 8'h23, 16'd0}) begin
            n_fail++;
            $display("FAIL lock_final: got locked=%0d exp=%02h cnt=%0d want 1 23 0",
                     bus0.locked, bus0.expected, bus0.err_count);
        end
    endtask

    task automatic test_single_error();
        step(0, 1'b1, 8'h00, 1'b0);
        n_tests++;
        if ({bus0.locked, bus0.err_pulse, bus0.err_count} !== {1'b1, 1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL single_err: got locked=%0d pulse=%0d cnt=%0d want 1 1 1",
                     bus0.locked, bus0.err_pulse, bus0.err_count);
        end
        step(0, 1'b1, 8'h46, 1'b0);
        // 0x46 has no tap bits set, so the next value is 0x46 shifted left: 0x8C.
        n_tests++;
        if ({bus0.locked, bus0.err_pulse, bus0.err_count, bus0.expected} !==
            {1'b1, 1'b0, 16'd1, 8'h8C}) begin
            n_fail++;
            $display("FAIL flywheel: got %07h want %07h", obs(0), {1'b1, 1'b0, 16'd1, 8'h8C});
        end
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, 8'hFF, 1'b0);
            n_tests++;
            if (obs(0) !== mdl(0)) begin
                n_fail++;
                $display("FAIL unlock_step%0d: got %07h want %07h", i, obs(0), mdl(0));
            end
        end
        n_tests++;
        if ({bus0.locked, bus0.err_count} !== {1'b0, 16'd4}) begin
            n_fail++;
            $display("FAIL unlock_final: got locked=%0d cnt=%0d want 0 4",
                     bus0.locked, bus0.err_count);
        end
        step(0, 1'b1, 8'h5A, 1'b0);
        n_tests++;
        if ({bus0.locked, bus0.err_pulse, bus0.expected} !== {1'b0, 1'b0, nx(8'h5A)}) begin
            n_fail++;
            $display("FAIL reseed_after_unlock: got exp=%02h locked=%0d want %02h 0",
                     bus0.expected, bus0.locked, nx(8'h5A));
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        step(0, 1'b1, 8'h00, 1'b0);
        n_tests++;
        if (obs(0) !== 26'd0) begin
            n_fail++;
            $display("FAIL zero_in_hunt: got %07h want 0000000", obs(0));
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b1, lock_seq[i], 1'b0);
            if (i < 4) begin
                step(0, 1'b0, 8'($urandom), 1'b0);
                step(0, 1'b0, 8'($urandom), 1'b0);
            end
            n_tests++;
            if (obs(0) !== mdl(0)) begin
                n_fail++;
                $display("FAIL gaps_step%0d: got %07h want %07h", i, obs(0), mdl(0));
            end
        end
        n_tests++;
        if ({bus0.locked, bus0.expected} !== {1'b1, 8'h23}) begin
            n_fail++;
            $display("FAIL gaps_lock: got locked=%0d exp=%02h want 1 23",
                     bus0.locked, bus0.expected);
        end
    endtask

    task automatic test_random();
        int errs;
        logic [7:0] d;
        int r;
        apply_reset();
        errs = 0;
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80 && m_mode[0] != 0) d = m_exp[0];
            else if (r < 86)              d = 8'h00;
            else                          d = 8'($urandom);
            step(0, ($urandom_range(0, 9) < 8), d, 1'b0);
            if (obs(0) !== mdl(0)) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_step%0d: got %07h want %07h", i, obs(0), mdl(0));
            end
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL random_stream: got %0d bad cycles want 0", errs);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        do_lock(1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1'b1, m_exp[1] ^ 8'h3C, 1'b0);
            n_tests++;
            if (obs(1) !== mdl(1)) begin
                n_fail++;
                $display("FAIL sat_step%0d: got %07h want %07h", i, obs(1), mdl(1));
            end
        end
        n_tests++;
        if ({bus1.locked, bus1.err_count} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL saturation: got locked=%0d cnt=%0d want 1 3",
                     bus1.locked, bus1.err_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_lock(0);
        step(0, 1'b1, 8'h00, 1'b0);
        apply_reset();
        n_tests++;
        if (obs(0) !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_mid_locked: got %07h want 0000000", obs(0));
        end
        step(0, 1'b1, 8'h02, 1'b0);
        n_tests++;
        if (obs(0) !== mdl(0)) begin
            n_fail++;
            $display("FAIL hunt_after_reset: got %07h want %07h", obs(0), mdl(0));
        end
    endtask

`ifdef RND_SEQ_CHECKER_CLR_EN
    task automatic test_err_clr();
        apply_reset();
        do_lock(0);
        step(0, 1'b1, 8'h00, 1'b0);
        step(0, 1'b1, 8'h00, 1'b1);
        n_tests++;
        if ({bus0.locked, bus0.err_pulse, bus0.err_count} !== {1'b1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL err_clr_vs_miss: got locked=%0d pulse=%0d cnt=%0d want 1 1 0",
                     bus0.locked, bus0.err_pulse, bus0.err_count);
        end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        bus0.rnd_valid = 1'b0;
        bus0.rnd_in    = 8'h00;
        bus1.rnd_valid = 1'b0;
        bus1.rnd_in    = 8'h00;
`ifdef RND_SEQ_CHECKER_CLR_EN
        bus0.err_clr   = 1'b0;
        bus1.err_clr   = 1'b0;
`endif
        model_clear();

        test_reset();
        test_lock();
        test_single_error();
        test_unlock();
        test_gaps();
        test_random();
        test_saturation();
        test_reset_mid();
`ifdef RND_SEQ_CHECKER_CLR_EN
        test_err_clr();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
